ifetch_unit: RTL

// - Instruction fetch front end; producer side of the fetch->decode handshake.
// - Walks the PC, requests 32-bit words from the memory controller, and buffers {pc, instr} in a FIFO.
// - Presents one instruction per cycle to Decoder (IF_success/instr/fetch_pc) unless back-pressured.
// - A ROB redirect flushes the FIFO and restarts fetch at the target PC.

---
 rtl/ifetch_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: walks the PC, fetches words from memory into a FIFO
// and presents one {pc, instr} per cycle to decode. Optional I-cache under ICACHE_EN.
module ifetch_unit #(
  parameter int QUEUE_DEPTH  = 8,
  parameter int ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        IF_success,
  output logic [31:0] instr,
  output logic [31:0] fetch_pc
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("QUEUE_DEPTH must be a power of two >= 2");
  end
  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two >= 2");
  end

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            if_ok_q, if_ok_d;
  logic [31:0]     instr_q, instr_d, fpc_q, fpc_d;
  logic [31:0]     fifo_pc_q  [QUEUE_DEPTH];
  logic [31:0]     fifo_ins_q [QUEUE_DEPTH];

  logic            push_en, pop_en, fill_en, hit;
  logic [31:0]     push_ins, hit_data;

`ifdef ICACHE_EN
  localparam int IW = $clog2(ICACHE_LINES);
  localparam int TW = 32 - IW - 2;
  logic [ICACHE_LINES-1:0] cvalid_q;
  logic [TW-1:0]           ctag_q  [ICACHE_LINES];
  logic [31:0]             cdata_q [ICACHE_LINES];
  logic [IW-1:0]           ridx, fidx;

  assign ridx     = pc_q[IW+1:2];
  assign fidx     = mem_addr_q[IW+1:2];
  assign hit      = cvalid_q[ridx] && (ctag_q[ridx] == pc_q[31:IW+2]);
  assign hit_data = cdata_q[ridx];

  always_ff @(posedge clk) begin
    if (rst)                  cvalid_q       <= '0;
    else if (rdy && fill_en)  cvalid_q[fidx] <= 1'b1;
  end

  // Fill is indexed by the request address: pc may already point elsewhere.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_en) begin
      ctag_q[fidx]  <= mem_addr_q[31:IW+2];
      cdata_q[fidx] <= mem_data;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push_en    = 1'b0;
    push_ins   = mem_data;
    fill_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (count_q != CW'(QUEUE_DEPTH)) begin
          if (hit) begin
            push_en  = 1'b1;
            push_ins = hit_data;
            pc_d     = pc_q + 32'd4;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
            state_d    = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          state_d   = S_IDLE;
          if (redirect) begin
            pc_d = redirect_pc;
          end else if (!drop_q) begin
            push_en = 1'b1;
            fill_en = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end else if (redirect) begin
          // Request cannot be cancelled; let it complete and discard the word.
          drop_d = 1'b1;
          pc_d   = redirect_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pop_en  = (count_q != '0) && !stall && !redirect;
    if_ok_d = pop_en;
    instr_d = pop_en ? fifo_ins_q[head_q] : instr_q;
    fpc_d   = pop_en ? fifo_pc_q[head_q]  : fpc_q;

    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop_en);
      tail_d  = tail_q + PW'(push_en);
      count_d = count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      drop_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      if_ok_q    <= 1'b0;
      instr_q    <= '0;
      fpc_q      <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if_ok_q    <= if_ok_d;
      instr_q    <= instr_d;
      fpc_q      <= fpc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && push_en) begin
      fifo_pc_q[tail_q]  <= pc_q;
      fifo_ins_q[tail_q] <= push_ins;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign IF_success = if_ok_q;
  assign instr      = instr_q;
  assign fetch_pc   = fpc_q;
endmodule
